// File: rtl/piece_controller.sv
// rtl/piece_controller.sv - falling-piece position/rotation controller for a block-stacking playfield
//
// Purpose: owns the active piece's shape, orientation and top-left pixel
// position. Spawns pieces, applies player moves and gravity on frame ticks,
// trial-checks rotations against the playfield and pulses landed at the floor.
//
// Ports:
//   Clk, Reset_n                  clock, asynchronous active-low reset
//   frame_tick                    one-cycle pulse per video frame
//   spawn_req, new_shape[2:0]     spawn request and shape code (1..7)
//   move_left, move_right,
//   rotate, drop_fast             player controls, acted on only on frame_tick
//   shape_size_x/_y[9:0]          bounding box from external lookup of
//                                 {shape_num, query_rotation}
//   shape_num, rotation           committed shape and orientation
//   query_rotation                orientation presented to the size lookup
//   piece_x, piece_y              top-left of bounding box (px)
//   active, landed                piece falling; one-cycle landing pulse
module piece_controller #(
  parameter int FIELD_X0      = 240,
  parameter int FIELD_Y0      = 80,
  parameter int FIELD_W       = 160,
  parameter int FIELD_H       = 320,
  parameter int GRAVITY_TICKS = 30,
  parameter int FAST_TICKS    = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       spawn_req,
  input  logic [2:0] new_shape,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       rotate,
  input  logic       drop_fast,
  input  logic [9:0] shape_size_x,
  input  logic [9:0] shape_size_y,
  output logic [2:0] shape_num,
  output logic [1:0] rotation,
  output logic [1:0] query_rotation,
  output logic [9:0] piece_x,
  output logic [9:0] piece_y,
  output logic       active,
  output logic       landed
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FALLING   = 2'd1,
    ROT_CHECK = 2'd2,
    LANDED    = 2'd3
  } state_t;

  localparam logic [9:0]  X_RESET  = 10'(FIELD_X0);
  localparam logic [9:0]  Y_RESET  = 10'(FIELD_Y0);
  localparam logic [9:0]  X_SPAWN  = 10'(FIELD_X0 + 64);
  localparam logic [10:0] X_LEFT   = 11'(FIELD_X0 + 16);
  localparam logic [10:0] X_LIMIT  = 11'(FIELD_X0 + FIELD_W);
  localparam logic [10:0] Y_LIMIT  = 11'(FIELD_Y0 + FIELD_H);
  localparam logic [7:0]  CNT_GRAV = 8'(GRAVITY_TICKS - 1);
  localparam logic [7:0]  CNT_FAST = 8'(FAST_TICKS - 1);

  state_t     state_q, state_d;
  logic [2:0] shape_q, shape_d;
  logic [1:0] rot_q, rot_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [7:0] cnt_q, cnt_d;

  // Bound sums are widened to 11 bits so a large size can never wrap
  // around and falsely pass a comparison.
  logic [10:0] right_edge, bottom_edge, x_ext;
  logic [7:0]  cnt_lim;

  assign x_ext       = {1'b0, x_q};
  assign right_edge  = x_ext + {1'b0, shape_size_x};
  assign bottom_edge = {1'b0, y_q} + {1'b0, shape_size_y};
  assign cnt_lim     = drop_fast ? CNT_FAST : CNT_GRAV;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      shape_q <= 3'd0;
      rot_q   <= 2'd0;
      x_q     <= X_RESET;
      y_q     <= Y_RESET;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      shape_q <= shape_d;
      rot_q   <= rot_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shape_d = shape_q;
    rot_d   = rot_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (spawn_req && (new_shape != 3'd0)) begin
          shape_d = new_shape;
          rot_d   = 2'd0;
          x_d     = X_SPAWN;
          y_d     = Y_RESET;
          cnt_d   = 8'd0;
          state_d = FALLING;
        end
      end
      FALLING: begin
        if (frame_tick) begin
          if (rotate) begin
            // Rotation tick is exclusive: no move, no gravity this frame.
            state_d = ROT_CHECK;
          end else begin
            // Lateral checks use the current (pre-move) bounding box.
            if (move_left && !move_right && (x_ext >= X_LEFT)) begin
              x_d = x_q - 10'd16;
            end else if (move_right && !move_left &&
                         ((right_edge + 11'd16) <= X_LIMIT)) begin
              x_d = x_q + 10'd16;
            end
            if (cnt_q >= cnt_lim) begin
              cnt_d = 8'd0;
              if ((bottom_edge + 11'd16) <= Y_LIMIT) begin
                y_d = y_q + 10'd16;
              end else begin
                state_d = LANDED;
              end
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
      end
      ROT_CHECK: begin
        // Size inputs here describe the trial orientation (query_rotation).
        if ((right_edge <= X_LIMIT) && (bottom_edge <= Y_LIMIT)) begin
          rot_d = rot_q + 2'd1;
        end
        state_d = FALLING;
      end
      LANDED: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign shape_num      = shape_q;
  assign rotation       = rot_q;
  assign query_rotation = (state_q == ROT_CHECK) ? (rot_q + 2'd1) : rot_q;
  assign piece_x        = x_q;
  assign piece_y        = y_q;
  assign active         = (state_q == FALLING) || (state_q == ROT_CHECK);
  assign landed         = (state_q == LANDED);

endmodule

// File: tb/tb_piece_controller.sv
// tb/tb_piece_controller.sv - scoreboard bench for piece_controller
module tb_piece_controller;

  logic       Clk;
  logic       Reset_n;
  logic       frame_tick;
  logic       spawn_req;
  logic [2:0] new_shape;
  logic       move_left;
  logic       move_right;
  logic       rotate;
  logic       drop_fast;
  logic [9:0] shape_size_x;
  logic [9:0] shape_size_y;
  logic [2:0] shape_num;
  logic [1:0] rotation;
  logic [1:0] query_rotation;
  logic [9:0] piece_x;
  logic [9:0] piece_y;
  logic       active;
  logic       landed;

  piece_controller dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .frame_tick     (frame_tick),
    .spawn_req      (spawn_req),
    .new_shape      (new_shape),
    .move_left      (move_left),
    .move_right     (move_right),
    .rotate         (rotate),
    .drop_fast      (drop_fast),
    .shape_size_x   (shape_size_x),
    .shape_size_y   (shape_size_y),
    .shape_num      (shape_num),
    .rotation       (rotation),
    .query_rotation (query_rotation),
    .piece_x        (piece_x),
    .piece_y        (piece_y),
    .active         (active),
    .landed         (landed)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // External shape-size lookup: 1 = I (64x16 / 16x64), 2 = O (32x32),
  // others 48x32 / 32x48.
  always_comb begin
    shape_size_x = 10'd48;
    shape_size_y = 10'd32;
    case (shape_num)
      3'd1: begin
        shape_size_x = query_rotation[0] ? 10'd16 : 10'd64;
        shape_size_y = query_rotation[0] ? 10'd64 : 10'd16;
      end
      3'd2: begin
        shape_size_x = 10'd32;
        shape_size_y = 10'd32;
      end
      default: begin
        shape_size_x = query_rotation[0] ? 10'd32 : 10'd48;
        shape_size_y = query_rotation[0] ? 10'd48 : 10'd32;
      end
    endcase
  end

  typedef struct {
    int         tag;
    logic [2:0] shape;
    logic [1:0] rot;
    logic [1:0] qrot;
    logic [9:0] x;
    logic [9:0] y;
    logic       act;
    logic       lnd;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   tag_n = 0;

  task automatic push_exp(input logic [2:0] s, input logic [1:0] r,
                          input logic [1:0] qr, input int x, input int y,
                          input logic a, input logic l);
    exp_t t;
    t.tag   = tag_n;
    t.shape = s;
    t.rot   = r;
    t.qrot  = qr;
    t.x     = 10'(x);
    t.y     = 10'(y);
    t.act   = a;
    t.lnd   = l;
    tag_n++;
    q.push_back(t);
  endtask

  task automatic chk(input int tag, input string f, input int got, input int ex);
    n_cmp++;
    if (got != ex) begin
      n_bad++;
      $display("FAIL step%0d.%s got %0d expected %0d", tag, f, got, ex);
    end
  endtask

  // Monitor: compares one queued expectation per falling edge.
  always @(negedge Clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      chk(e.tag, "shape_num", int'(shape_num), int'(e.shape));
      chk(e.tag, "rotation", int'(rotation), int'(e.rot));
      chk(e.tag, "query_rotation", int'(query_rotation), int'(e.qrot));
      chk(e.tag, "piece_x", int'(piece_x), int'(e.x));
      chk(e.tag, "piece_y", int'(piece_y), int'(e.y));
      chk(e.tag, "active", int'(active), int'(e.act));
      chk(e.tag, "landed", int'(landed), int'(e.lnd));
    end
  end

  task automatic cyc(input logic t, input logic ml, input logic mr,
                     input logic ro, input logic df);
    frame_tick = t;
    move_left  = ml;
    move_right = mr;
    rotate     = ro;
    drop_fast  = df;
    @(posedge Clk);
    #1;
    frame_tick = 1'b0;
    move_left  = 1'b0;
    move_right = 1'b0;
    rotate     = 1'b0;
    drop_fast  = 1'b0;
  endtask

  task automatic spawn(input logic [2:0] s);
    spawn_req = 1'b1;
    new_shape = s;
    @(posedge Clk);
    #1;
    spawn_req = 1'b0;
    new_shape = 3'd0;
  endtask

  initial begin
    Reset_n    = 1'b0;
    frame_tick = 1'b0;
    spawn_req  = 1'b0;
    new_shape  = 3'd0;
    move_left  = 1'b0;
    move_right = 1'b0;
    rotate     = 1'b0;
    drop_fast  = 1'b0;

    // Reset state
    push_exp(0, 0, 0, 240, 80, 0, 0);
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;

    // new_shape 0 is ignored
    spawn(0);
    push_exp(0, 0, 0, 240, 80, 0, 0);

    // I piece spawn
    spawn(1);
    push_exp(1, 0, 0, 304, 80, 1, 0);

    // Right moves, third blocked at the right wall
    cyc(1, 0, 1, 0, 0); push_exp(1, 0, 0, 320, 80, 1, 0);
    cyc(1, 0, 1, 0, 0); push_exp(1, 0, 0, 336, 80, 1, 0);
    cyc(1, 0, 1, 0, 0); push_exp(1, 0, 0, 336, 80, 1, 0);

    // Left back to the wall, then blocked
    for (int i = 1; i <= 6; i++) begin
      cyc(1, 1, 0, 0, 0);
      push_exp(1, 0, 0, 336 - 16 * i, 80, 1, 0);
    end
    cyc(1, 1, 0, 0, 0); push_exp(1, 0, 0, 240, 80, 1, 0);

    // Right, then both pressed -> no move
    cyc(1, 0, 1, 0, 0); push_exp(1, 0, 0, 256, 80, 1, 0);
    cyc(1, 1, 1, 0, 0); push_exp(1, 0, 0, 256, 80, 1, 0);

    // Spawn while falling ignored; controls without tick ignored
    spawn(2);
    push_exp(1, 0, 0, 256, 80, 1, 0);
    cyc(0, 0, 1, 0, 0); push_exp(1, 0, 0, 256, 80, 1, 0);

    // Rotate with move_right: move suppressed, rotation committed at y=80
    cyc(1, 0, 1, 1, 0); push_exp(1, 0, 1, 256, 80, 1, 0);
    cyc(0, 0, 0, 0, 0); push_exp(1, 1, 1, 256, 80, 1, 0);
    cyc(1, 0, 0, 1, 0); push_exp(1, 1, 2, 256, 80, 1, 0);
    cyc(0, 0, 0, 0, 0); push_exp(1, 2, 2, 256, 80, 1, 0);

    // Normal gravity: 12 counted ticks so far; 30th tick drops
    for (int i = 0; i < 17; i++) cyc(1, 0, 0, 0, 0);
    push_exp(1, 2, 2, 256, 80, 1, 0);
    cyc(1, 0, 0, 0, 0); push_exp(1, 2, 2, 256, 96, 1, 0);

    // Fast drop from 96 to 384 (horizontal I, 16 tall)
    for (int k = 0; k < 18; k++) begin
      cyc(1, 0, 0, 0, 1); push_exp(1, 2, 2, 256, 96 + 16 * k, 1, 0);
      cyc(1, 0, 0, 0, 1); push_exp(1, 2, 2, 256, 112 + 16 * k, 1, 0);
    end

    // Rotate at y=384: vertical would overflow the floor, rotation kept
    cyc(1, 0, 0, 1, 0); push_exp(1, 2, 3, 256, 384, 1, 0);
    cyc(0, 0, 0, 0, 0); push_exp(1, 2, 2, 256, 384, 1, 0);

    // Land: one-cycle pulse then idle with position held
    cyc(1, 0, 0, 0, 1); push_exp(1, 2, 2, 256, 384, 1, 0);
    cyc(1, 0, 0, 0, 1); push_exp(1, 2, 2, 256, 384, 0, 1);
    cyc(0, 0, 0, 0, 0); push_exp(1, 2, 2, 256, 384, 0, 0);

    // O piece fast drop to 368 then land
    spawn(2);
    push_exp(2, 0, 0, 304, 80, 1, 0);
    for (int k = 0; k < 18; k++) begin
      cyc(1, 0, 0, 0, 1); push_exp(2, 0, 0, 304, 80 + 16 * k, 1, 0);
      cyc(1, 0, 0, 0, 1); push_exp(2, 0, 0, 304, 96 + 16 * k, 1, 0);
    end
    cyc(1, 0, 0, 0, 1); push_exp(2, 0, 0, 304, 368, 1, 0);
    cyc(1, 0, 0, 0, 1); push_exp(2, 0, 0, 304, 368, 0, 1);
    cyc(0, 0, 0, 0, 0); push_exp(2, 0, 0, 304, 368, 0, 0);

    // Reset mid-fall, between clock edges
    spawn(3);
    push_exp(3, 0, 0, 304, 80, 1, 0);
    cyc(1, 0, 1, 0, 0); push_exp(3, 0, 0, 320, 80, 1, 0);
    cyc(1, 0, 1, 0, 0);
    #1;
    Reset_n = 1'b0;
    push_exp(0, 0, 0, 240, 80, 0, 0);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    push_exp(0, 0, 0, 240, 80, 0, 0);
    @(posedge Clk);
    #1;
    push_exp(0, 0, 0, 240, 80, 0, 0);

    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge Clk);
    @(posedge Clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain pending %0d expected 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/piece_controller.md
PIECE_CONTROLLER -- requirements
Module: piece_controller

Interface
REQ-001 SHALL have parameter FIELD_X0, 240, playfield left edge (px).
REQ-002 SHALL have parameter FIELD_Y0, 80, playfield top edge (px).
REQ-003 SHALL have parameter FIELD_W, 160, playfield width (px, 10 cells of 16).
REQ-004 SHALL have parameter FIELD_H, 320, playfield height (px, 20 cells of 16).
REQ-005 SHALL have parameter GRAVITY_TICKS, 30, frame ticks per normal drop step.
REQ-006 SHALL have parameter FAST_TICKS, 2, frame ticks per drop step while drop_fast is high.
REQ-007 SHALL have ports: Clk  in  1  system clock; Reset_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have ports: frame_tick  in  1  one-cycle pulse per video frame; spawn_req  in  1  request new piece; new_shape  in  3  shape code for spawn (1..7).
REQ-009 SHALL have ports: move_left, move_right, rotate, drop_fast  in  1 each  player controls, sampled on frame_tick.
REQ-010 SHALL have ports: shape_size_x, shape_size_y  in  10 each  bounding box (px) returned combinationally by the shape-size lookup for {shape_num, query_rotation}.
REQ-011 SHALL have ports: shape_num  out  3; rotation  out  2  committed orientation; query_rotation  out  2  orientation presented to size lookup.
REQ-012 SHALL have ports: piece_x, piece_y  out  10 each  top-left of bounding box (px); active  out  1  piece falling; landed  out  1  one-cycle landing pulse.

Function
REQ-013 SHALL implement states IDLE, FALLING, ROT_CHECK, LANDED.
REQ-014 SHALL, in IDLE, on spawn_req with new_shape != 0: load shape_num=new_shape, rotation=0, piece_x=FIELD_X0+64, piece_y=FIELD_Y0, gravity counter=0, go FALLING next cycle; new_shape==0 ignored.
REQ-015 SHALL assert active exactly while in FALLING or ROT_CHECK.
REQ-016 SHALL, in FALLING, act only on cycles with frame_tick high; non-tick cycles hold all state.
REQ-017 SHALL, on a FALLING tick with rotate high, go ROT_CHECK and suppress lateral move, gravity and counter increment that tick.
REQ-018 SHALL drive query_rotation = rotation+1 (mod 4) in ROT_CHECK, = rotation otherwise.
REQ-019 SHALL, in ROT_CHECK (one cycle), commit rotation=query_rotation iff piece_x+shape_size_x <= FIELD_X0+FIELD_W and piece_y+shape_size_y <= FIELD_Y0+FIELD_H, else keep rotation; always return to FALLING.
REQ-020 SHALL, on a FALLING tick without rotate: move_left alone -> piece_x -= 16 iff piece_x >= FIELD_X0+16; move_right alone -> piece_x += 16 iff piece_x+shape_size_x+16 <= FIELD_X0+FIELD_W; both or neither -> no lateral move.
REQ-021 SHALL, on the same tick, increment the gravity counter; when counter >= (drop_fast ? FAST_TICKS : GRAVITY_TICKS)-1, clear it and perform a drop step.
REQ-022 SHALL, on a drop step, set piece_y += 16 iff piece_y+shape_size_y+16 <= FIELD_Y0+FIELD_H, else go LANDED with piece_y held.
REQ-023 SHALL evaluate lateral bounds with pre-move sizes; lateral move and drop on the same tick both apply.
REQ-024 SHALL compute all bound sums at 11 bits unsigned so no 10-bit wrap affects a comparison.
REQ-025 SHALL, in LANDED, pulse landed high for exactly one cycle, hold piece_x/piece_y/shape_num/rotation, and go IDLE next cycle.
REQ-026 SHALL ignore spawn_req outside IDLE.

Reset
REQ-027 SHALL, while Reset_n low (asynchronously): state IDLE, shape_num=0, rotation=0, query_rotation=0, piece_x=FIELD_X0, piece_y=FIELD_Y0, counter=0, active=0, landed=0.
REQ-028 SHALL abort any in-progress piece when reset asserts mid-operation; no landed pulse.

Verification
REQ-029 Spawn new_shape=1 -> next cycle active=1, piece_x=304, piece_y=80, rotation=0.
REQ-030 I piece (64x16), 3 ticks move_right -> piece_x 320, 336, 336 (third blocked); at x=240 move_left tick -> stays 240.
REQ-031 O piece (32x32), drop_fast held -> piece_y advances 16 every 2 ticks to 368; next drop step -> landed one-cycle pulse, active=0, piece_y=368, state IDLE.
REQ-032 Horizontal I at piece_y=384, rotate tick -> ROT_CHECK, query_rotation=1, rotation stays 0; at piece_y=80 -> rotation becomes 1.
REQ-033 move_left and move_right high on same tick -> piece_x unchanged; spawn_req while FALLING -> ignored.
REQ-034 Reset_n low mid-fall without clock edge -> outputs immediately at reset values.
